// File: rtl/clk_div_multi.sv
// Multi-channel programmable tick / divided-clock generator. Divisor and duty
// reloads are shadowed and applied at period boundaries. Optional macro: CLK_DIV_SYNC_RESTART_EN.
module clk_div_multi #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CLK_DIV_SYNC_RESTART_EN
  input  logic                    sync_restart,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] k_in,
  input  logic [NUM_CH*WIDTH-1:0] duty_in,
  output logic [NUM_CH-1:0]       tick_out,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       pend
);

  logic restart;
`ifdef CLK_DIV_SYNC_RESTART_EN
  assign restart = sync_restart;
`else
  assign restart = 1'b0;
`endif

  // Terminal count of a period; divisors of 0 and 1 saturate to divide-by-1.
  function automatic logic [WIDTH-1:0] last_count(input logic [WIDTH-1:0] k);
    return (k > WIDTH'(1)) ? k - WIDTH'(1) : '0;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_p0;
    logic [WIDTH-1:0] k_act;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] k_pend;
    logic [WIDTH-1:0] duty_pend;
    logic [WIDTH-1:0] last_p0;
    logic             pend_q;
    logic             at_end_p0;
    logic             wrap_p0;
    logic             take_p0;
    logic             tick_p1;
    logic             sq_p1;

    assign last_p0   = last_count(k_act);
    assign at_end_p0 = (cnt_p0 == last_p0);
    assign wrap_p0   = (cnt_p0 >= last_p0);
    assign take_p0   = pend_q & (restart | ~en[i] | at_end_p0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_p0    <= '0;
        k_act     <= '0;
        duty_act  <= '0;
        k_pend    <= '0;
        duty_pend <= '0;
        pend_q    <= 1'b0;
        tick_p1   <= 1'b0;
        sq_p1     <= 1'b0;
      end else begin
        // Counter stage p0 -> registered outputs p1
        if (restart) begin
          cnt_p0  <= '0;
          tick_p1 <= 1'b0;
          sq_p1   <= 1'b0;
        end else begin
          tick_p1 <= en[i] & at_end_p0;
          sq_p1   <= en[i] & (mode[i] ? (cnt_p0 < duty_act) : at_end_p0);
          cnt_p0  <= (!en[i] || wrap_p0) ? '0 : cnt_p0 + WIDTH'(1);
        end
        if (take_p0) begin
          k_act    <= k_pend;
          duty_act <= duty_pend;
        end
        // A same-edge load keeps the new values pending after the old ones apply.
        if (load[i] && !restart) begin
          k_pend    <= k_in[i*WIDTH +: WIDTH];
          duty_pend <= duty_in[i*WIDTH +: WIDTH];
          pend_q    <= 1'b1;
        end else if (take_p0) begin
          pend_q    <= 1'b0;
        end
      end
    end

    assign tick_out[i] = tick_p1;
    assign clk_out[i]  = sq_p1;
    assign pend[i]     = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus randomized traffic checked
// every cycle against a cycle-level behavioural model of the channel rules.
module tb_clk_div_multi;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       en = '0;
  logic [NUM_CH-1:0]       mode = '0;
  logic [NUM_CH-1:0]       load = '0;
  logic [NUM_CH*WIDTH-1:0] k_in = '0;
  logic [NUM_CH*WIDTH-1:0] duty_in = '0;
  logic [NUM_CH-1:0]       tick_out;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       pend;
`ifdef CLK_DIV_SYNC_RESTART_EN
  logic                    sync_restart = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // model state per channel
  int m_cnt[NUM_CH], m_kact[NUM_CH], m_dact[NUM_CH], m_kpend[NUM_CH], m_dpend[NUM_CH];
  int m_pend[NUM_CH], m_tick[NUM_CH], m_clk[NUM_CH];

  clk_div_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef CLK_DIV_SYNC_RESTART_EN
    .sync_restart(sync_restart),
`endif
    .en(en),
    .mode(mode),
    .load(load),
    .k_in(k_in),
    .duty_in(duty_in),
    .tick_out(tick_out),
    .clk_out(clk_out),
    .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_kact[i] = 0; m_dact[i] = 0; m_kpend[i] = 0; m_dpend[i] = 0;
      m_pend[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
    end
  endtask

  // One rising edge of the specified behaviour, using the inputs held before the edge.
  task automatic model_step();
    int sr;
    sr = 0;
`ifdef CLK_DIV_SYNC_RESTART_EN
    sr = int'(sync_restart);
`endif
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      int keff, kin, din, last, take;
      kin  = int'(k_in[i*WIDTH +: WIDTH]);
      din  = int'(duty_in[i*WIDTH +: WIDTH]);
      keff = (m_kact[i] > 1) ? m_kact[i] : 1;
      last = (m_cnt[i] == keff - 1) ? 1 : 0;
      if (sr != 0) begin
        m_cnt[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
        if (m_pend[i] != 0) begin
          m_kact[i] = m_kpend[i]; m_dact[i] = m_dpend[i];
        end
        m_pend[i] = 0;
      end else begin
        m_tick[i] = (en[i] && last != 0) ? 1 : 0;
        if (mode[i]) m_clk[i] = (en[i] && m_cnt[i] < m_dact[i]) ? 1 : 0;
        else         m_clk[i] = m_tick[i];
        take = (m_pend[i] != 0 && (!en[i] || last != 0)) ? 1 : 0;
        if (take != 0) begin
          m_kact[i] = m_kpend[i]; m_dact[i] = m_dpend[i];
        end
        if (load[i]) begin
          m_kpend[i] = kin; m_dpend[i] = din; m_pend[i] = 1;
        end else if (take != 0) begin
          m_pend[i] = 0;
        end
        m_cnt[i] = (!en[i] || m_cnt[i] >= keff - 1) ? 0 : m_cnt[i] + 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("model_tick[%0d]", i), 32'(tick_out[i]), m_tick[i]);
      check($sformatf("model_clk[%0d]", i), 32'(clk_out[i]), m_clk[i]);
      check($sformatf("model_pend[%0d]", i), 32'(pend[i]), m_pend[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_k(input int ch, input int k, input int d);
    k_in[ch*WIDTH +: WIDTH]    = WIDTH'(k);
    duty_in[ch*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #11;
    check("reset_tick", 32'(tick_out), 0);
    check("reset_clk", 32'(clk_out), 0);
    check("reset_pend", 32'(pend), 0);
    @(negedge clk);
    rst = 1'b1;

    // divide-by-4 tick on ch0
    set_k(0, 4, 0); load[0] = 1'b1;
    cyc();
    check("pend_after_load", 32'(pend[0]), 1);
    load[0] = 1'b0;
    cyc();
    check("pend_applied", 32'(pend[0]), 0);
    en[0] = 1'b1; mode[0] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      cyc();
      check("tick_k4", 32'(tick_out[0]), 32'(j % 4 == 3));
      check("clkout_k4", 32'(clk_out[0]), 32'(j % 4 == 3));
    end

    // square wave ch1 k=5 duty=2
    set_k(1, 5, 2); load[1] = 1'b1;
    cyc();
    load[1] = 1'b0;
    cyc();
    en[1] = 1'b1; mode[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      cyc();
      check("square_5_2", 32'(clk_out[1]), 32'(j % 5 < 2));
    end
    set_k(1, 5, 0); load[1] = 1'b1;
    cyc();
    load[1] = 1'b0;
    repeat (6) cyc();
    for (int j = 0; j < 5; j++) begin
      cyc();
      check("square_duty0", 32'(clk_out[1]), 0);
    end
    set_k(1, 5, 7); load[1] = 1'b1;
    cyc();
    load[1] = 1'b0;
    repeat (6) cyc();
    for (int j = 0; j < 5; j++) begin
      cyc();
      check("square_duty7", 32'(clk_out[1]), 1);
    end

    // boundary divisors: k=0 (ch2), k=1 (ch3), then k=2 (ch2)
    en[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc();
      check("tick_k0", 32'(tick_out[2]), 1);
    end
    set_k(3, 1, 0); load[3] = 1'b1;
    cyc();
    load[3] = 1'b0;
    cyc();
    en[3] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc();
      check("tick_k1", 32'(tick_out[3]), 1);
    end
    en[2] = 1'b0; set_k(2, 2, 0); load[2] = 1'b1;
    cyc();
    load[2] = 1'b0;
    cyc();
    en[2] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cyc();
      check("tick_k2", 32'(tick_out[2]), 32'(j % 2 == 1));
    end

    // glitch-free reload: k=8 running, load k=3 at counter 2
    en[0] = 1'b0; set_k(0, 8, 0); load[0] = 1'b1;
    cyc();
    load[0] = 1'b0;
    cyc();
    en[0] = 1'b1;
    for (int j = 0; j < 17; j++) begin
      if (j == 2) begin
        set_k(0, 3, 0); load[0] = 1'b1;
      end else begin
        load[0] = 1'b0;
      end
      cyc();
      check("reload_tick", 32'(tick_out[0]), 32'(j == 7 || j == 10 || j == 13 || j == 16));
      check("reload_pend", 32'(pend[0]), 32'(j >= 2 && j <= 6));
    end
    load[0] = 1'b0;

    // asynchronous reset mid-operation (ch3 is ticking continuously)
    repeat (5) cyc();
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_tick", 32'(tick_out), 0);
    check("async_rst_clk", 32'(clk_out), 0);
    check("async_rst_pend", 32'(pend), 0);
    #2 rst = 1'b1;
    en = '0; mode = '0;

    // en toggle restarts phase
    set_k(0, 4, 0); load[0] = 1'b1;
    cyc();
    load[0] = 1'b0;
    cyc();
    en[0] = 1'b1;
    repeat (6) cyc();
    en[0] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      cyc();
      check("en_off_tick", 32'(tick_out[0]), 0);
      check("en_off_clk", 32'(clk_out[0]), 0);
    end
    en[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      cyc();
      check("en_restart_tick", 32'(tick_out[0]), 32'(j % 4 == 3));
    end

`ifdef CLK_DIV_SYNC_RESTART_EN
    // phase alignment of k=4 and k=6 through sync_restart
    set_k(1, 6, 0); load[1] = 1'b1;
    cyc();
    load[1] = 1'b0;
    cyc();
    en[1] = 1'b1;
    repeat ($urandom_range(1, 7)) cyc();
    sync_restart = 1'b1;
    cyc();
    sync_restart = 1'b0;
    for (int j = 0; j < 12; j++) begin
      cyc();
      check("sync_coincide", 32'(tick_out[0] & tick_out[1]), 32'(j == 11));
    end
`endif

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 29) == 0) mode[i] = ~mode[i];
        load[i] = ($urandom_range(0, 9) == 0);
        if (load[i]) set_k(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
      end
`ifdef CLK_DIV_SYNC_RESTART_EN
      sync_restart = ($urandom_range(0, 49) == 0);
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
